// File: rtl/core_bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// core_bus_arbiter_if
// Bundles the core-side channel buses and the controller-side memory port
// shared by core_bus_arbiter.
//   ch_read/ch_write        per-channel request levels, held until ch_response
//   ch_address/write_data   channel i packed at [i*BUS_WIDTH +: BUS_WIDTH]
//   ch_read_data            per-channel registered read data
//   ch_response             one-cycle completion pulse per channel
//   mem_read/mem_write      request to the memory controller
//   mem_address/write_data  registered request payload
//   mem_read_data           controller read data, valid with mem_response
//   mem_response            controller completion pulse
// Modports: slave is the arbiter's view, master is the surrounding system.
// ---------------------------------------------------------------------------
interface core_bus_arbiter_if #(
    parameter int unsigned NUM_PORTS = 2,
    parameter int unsigned BUS_WIDTH = 32
);
    logic [NUM_PORTS-1:0]           ch_read;
    logic [NUM_PORTS-1:0]           ch_write;
    logic [NUM_PORTS*BUS_WIDTH-1:0] ch_address;
    logic [NUM_PORTS*BUS_WIDTH-1:0] ch_write_data;
    logic [NUM_PORTS*BUS_WIDTH-1:0] ch_read_data;
    logic [NUM_PORTS-1:0]           ch_response;
    logic                           mem_read;
    logic                           mem_write;
    logic [BUS_WIDTH-1:0]           mem_address;
    logic [BUS_WIDTH-1:0]           mem_write_data;
    logic [BUS_WIDTH-1:0]           mem_read_data;
    logic                           mem_response;

    modport slave (
        input  ch_read, ch_write, ch_address, ch_write_data, mem_read_data, mem_response,
        output ch_read_data, ch_response, mem_read, mem_write, mem_address, mem_write_data
    );

    modport master (
        output ch_read, ch_write, ch_address, ch_write_data, mem_read_data, mem_response,
        input  ch_read_data, ch_response, mem_read, mem_write, mem_address, mem_write_data
    );
endinterface

// File: rtl/core_bus_arbiter.sv
// ---------------------------------------------------------------------------
// core_bus_arbiter
// Shares one memory-controller port among NUM_PORTS core-side channels with
// round-robin arbitration, per-channel read-data holding and a watchdog that
// aborts stalled transactions and records the first offending channel.
// Ports:
//   i_clk             system clock
//   i_rst_n           asynchronous active-low reset
//   io_bus            channel and memory buses (slave modport)
//   o_grant           one-hot owner of the current transaction, 0 when idle
//   o_busy            high while a transaction is in BUSY or DONE
//   o_timeout_error   sticky watchdog flag, cleared only by reset
//   o_error_channel   channel of the first timeout
// ---------------------------------------------------------------------------
module core_bus_arbiter #(
    parameter int unsigned NUM_PORTS      = 2,
    parameter int unsigned BUS_WIDTH      = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    localparam int unsigned IDX_W         = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    core_bus_arbiter_if.slave       io_bus,
    output logic [NUM_PORTS-1:0]    o_grant,
    output logic                    o_busy,
    output logic                    o_timeout_error,
    output logic [IDX_W-1:0]        o_error_channel
);
    localparam logic [1:0]  ST_IDLE   = 2'd0;
    localparam logic [1:0]  ST_BUSY   = 2'd1;
    localparam logic [1:0]  ST_DONE   = 2'd2;
    localparam bit          WDOG_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [31:0] WDOG_LAST = 32'(TIMEOUT_CYCLES - 1);

    logic [1:0]                     r_state;
    logic [IDX_W-1:0]               r_last_grant;
    logic [NUM_PORTS-1:0]           r_grant;
    logic [IDX_W-1:0]               r_gidx;
    logic                           r_is_write;
    logic                           r_mem_read;
    logic                           r_mem_write;
    logic [BUS_WIDTH-1:0]           r_mem_address;
    logic [BUS_WIDTH-1:0]           r_mem_write_data;
    logic [NUM_PORTS*BUS_WIDTH-1:0] r_ch_read_data;
    logic [NUM_PORTS-1:0]           r_ch_response;
    logic [31:0]                    r_wdog;
    logic                           r_timeout_error;
    logic [IDX_W-1:0]               r_error_channel;

    logic [NUM_PORTS-1:0]           w_req;
    logic [NUM_PORTS-1:0]           w_sel_onehot;
    logic [IDX_W-1:0]               w_sel_idx;
    logic                           w_sel_found;
    logic [BUS_WIDTH-1:0]           w_sel_addr;
    logic [BUS_WIDTH-1:0]           w_sel_wdata;
    logic                           w_sel_write;
    logic                           w_timeout;

    assign w_req = io_bus.ch_read | io_bus.ch_write;

    // Scan starts one past the previous owner so every requester is served in turn.
    always_comb begin
        w_sel_onehot = '0;
        w_sel_idx    = '0;
        w_sel_found  = 1'b0;
        for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
            int unsigned scan;
            scan = (32'(r_last_grant) + k) % NUM_PORTS;
            if (!w_sel_found && w_req[scan[IDX_W-1:0]]) begin
                w_sel_found                    = 1'b1;
                w_sel_idx                      = scan[IDX_W-1:0];
                w_sel_onehot[scan[IDX_W-1:0]]  = 1'b1;
            end
        end
    end

    always_comb begin
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (w_sel_onehot[i]) begin
                w_sel_addr  = io_bus.ch_address[i*BUS_WIDTH +: BUS_WIDTH];
                w_sel_wdata = io_bus.ch_write_data[i*BUS_WIDTH +: BUS_WIDTH];
            end
        end
    end

    // A channel raising both read and write is treated as a write.
    assign w_sel_write = |(w_sel_onehot & io_bus.ch_write);
    assign w_timeout   = WDOG_EN && (r_wdog == WDOG_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state          <= ST_IDLE;
            r_last_grant     <= IDX_W'(NUM_PORTS - 1);
            r_grant          <= '0;
            r_gidx           <= '0;
            r_is_write       <= 1'b0;
            r_mem_read       <= 1'b0;
            r_mem_write      <= 1'b0;
            r_mem_address    <= '0;
            r_mem_write_data <= '0;
            r_ch_read_data   <= '0;
            r_ch_response    <= '0;
            r_wdog           <= '0;
            r_timeout_error  <= 1'b0;
            r_error_channel  <= '0;
        end else begin
            r_ch_response <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_sel_found) begin
                        r_grant          <= w_sel_onehot;
                        r_gidx           <= w_sel_idx;
                        r_is_write       <= w_sel_write;
                        r_mem_read       <= !w_sel_write;
                        r_mem_write      <= w_sel_write;
                        r_mem_address    <= w_sel_addr;
                        r_mem_write_data <= w_sel_wdata;
                        r_wdog           <= '0;
                        r_state          <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    // A response arriving on the timeout cycle still counts as a completion.
                    if (io_bus.mem_response || w_timeout) begin
                        r_mem_read    <= 1'b0;
                        r_mem_write   <= 1'b0;
                        r_ch_response <= r_grant;
                        r_last_grant  <= r_gidx;
                        r_wdog        <= '0;
                        r_state       <= ST_DONE;
                        if (!r_is_write) begin
                            for (int i = 0; i < NUM_PORTS; i++) begin
                                if (r_grant[i]) begin
                                    r_ch_read_data[i*BUS_WIDTH +: BUS_WIDTH] <=
                                        io_bus.mem_response ? io_bus.mem_read_data : '1;
                                end
                            end
                        end
                        if (!io_bus.mem_response && !r_timeout_error) begin
                            r_timeout_error <= 1'b1;
                            r_error_channel <= r_gidx;
                        end
                    end else begin
                        r_wdog <= r_wdog + 32'd1;
                    end
                end
                ST_DONE: begin
                    // Single gap cycle lets the finished requester drop its request.
                    r_grant <= '0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign io_bus.mem_read       = r_mem_read;
    assign io_bus.mem_write      = r_mem_write;
    assign io_bus.mem_address    = r_mem_address;
    assign io_bus.mem_write_data = r_mem_write_data;
    assign io_bus.ch_read_data   = r_ch_read_data;
    assign io_bus.ch_response    = r_ch_response;
    assign o_grant               = r_grant;
    assign o_busy                = (r_state != ST_IDLE);
    assign o_timeout_error       = r_timeout_error;
    assign o_error_channel       = r_error_channel;
endmodule

// File: tb/tb_core_bus_arbiter.sv
module tb_core_bus_arbiter;
    localparam int NP = 3;
    localparam int BW = 32;
    localparam int TO = 8;

    typedef struct {
        int          port;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          delay;   // cycles before mem_response; negative means never
        logic [2:0]  drop;    // requests released at DONE
    } item_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NP-1:0] grant;
    logic          busy;
    logic          terr;
    logic [1:0]    echan;

    item_t         sb[$];
    logic [31:0]   exp_rd[NP];
    bit            exp_terr;
    logic [1:0]    exp_echan;
    int            total = 0;
    int            bad   = 0;

    always #5 clk = ~clk;

    core_bus_arbiter_if #(.NUM_PORTS(NP), .BUS_WIDTH(BW)) bus ();

    core_bus_arbiter #(
        .NUM_PORTS      (NP),
        .BUS_WIDTH      (BW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .io_bus          (bus),
        .o_grant         (grant),
        .o_busy          (busy),
        .o_timeout_error (terr),
        .o_error_channel (echan)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rd_slot(input int p);
        return bus.ch_read_data[p*BW +: BW];
    endfunction

    task automatic push(input int p, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rd, input int dly, input logic [2:0] drop);
        item_t it;
        it.port = p; it.wr = wr; it.addr = a; it.wdata = wd;
        it.rdata = rd; it.delay = dly; it.drop = drop;
        sb.push_back(it);
    endtask

    task automatic set_req(input int p, input bit rd, input bit wr, input logic [31:0] a,
                           input logic [31:0] wd);
        bus.ch_read[p]                = rd;
        bus.ch_write[p]               = wr;
        bus.ch_address[p*BW +: BW]    = a;
        bus.ch_write_data[p*BW +: BW] = wd;
    endtask

    // Pops the next expected transaction, plays the controller and checks the DONE/IDLE cycles.
    task automatic serve();
        item_t         it;
        bit            seen;
        logic [NP-1:0] oh;
        it = sb.pop_front();
        oh = '0;
        oh[it.port] = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            seen = bus.mem_read | bus.mem_write;
        end
        chk("mem_request_seen", 64'(seen), 64'd1);
        if (!seen) return;
        chk("busy_grant", 64'(grant), 64'(oh));
        chk("busy_flag", 64'(busy), 64'd1);
        chk("mem_address", 64'(bus.mem_address), 64'(it.addr));
        chk("mem_write", 64'(bus.mem_write), 64'(it.wr));
        chk("mem_read", 64'(bus.mem_read), 64'(!it.wr));
        if (it.wr) chk("mem_write_data", 64'(bus.mem_write_data), 64'(it.wdata));
        if (it.delay >= 0) begin
            repeat (it.delay) @(negedge clk);
            bus.mem_response  = 1'b1;
            bus.mem_read_data = it.rdata;
            @(negedge clk);
            bus.mem_response  = 1'b0;
            bus.mem_read_data = '0;
            if (!it.wr) exp_rd[it.port] = it.rdata;
        end else begin
            repeat (TO - 1) @(negedge clk);
            chk("pre_timeout_resp", 64'(bus.ch_response), 64'd0);
            chk("pre_timeout_req", 64'(bus.mem_read | bus.mem_write), 64'd1);
            @(negedge clk);
            if (!it.wr) exp_rd[it.port] = '1;
            if (!exp_terr) exp_echan = it.port[1:0];
            exp_terr = 1'b1;
        end
        chk("done_resp", 64'(bus.ch_response), 64'(oh));
        chk("done_grant", 64'(grant), 64'(oh));
        chk("done_busy", 64'(busy), 64'd1);
        chk("done_mem_idle", 64'({bus.mem_read, bus.mem_write}), 64'd0);
        chk("read_data_slot", 64'(rd_slot(it.port)), 64'(exp_rd[it.port]));
        chk("timeout_error", 64'(terr), 64'(exp_terr));
        chk("error_channel", 64'(echan), 64'(exp_echan));
        bus.ch_read  = bus.ch_read & ~it.drop;
        bus.ch_write = bus.ch_write & ~it.drop;
        @(negedge clk);
        chk("idle_grant", 64'(grant), 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_resp", 64'(bus.ch_response), 64'd0);
    endtask

    initial begin
        bit seen;
        rst_n = 1'b0;
        bus.ch_read = '0; bus.ch_write = '0; bus.ch_address = '0; bus.ch_write_data = '0;
        bus.mem_read_data = '0; bus.mem_response = 1'b0;
        for (int i = 0; i < NP; i++) exp_rd[i] = '0;
        exp_terr = 1'b0; exp_echan = '0;
        repeat (2) @(negedge clk);

        chk("rst_grant", 64'(grant), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_mem_req", 64'({bus.mem_read, bus.mem_write}), 64'd0);
        chk("rst_mem_address", 64'(bus.mem_address), 64'd0);
        chk("rst_resp", 64'(bus.ch_response), 64'd0);
        chk("rst_read_data", 64'(bus.ch_read_data[63:0]), 64'd0);
        chk("rst_terr", 64'(terr), 64'd0);
        chk("rst_echan", 64'(echan), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // ch0 and ch1 both reading from reset: ch0 first, then alternating.
        set_req(0, 1'b1, 1'b0, 32'h0000_0200, 32'h0);
        set_req(1, 1'b1, 1'b0, 32'h0000_0300, 32'h0);
        push(0, 1'b0, 32'h200, 32'h0, 32'hA000_0001, 0, 3'b000);
        push(1, 1'b0, 32'h300, 32'h0, 32'hB000_0001, 1, 3'b000);
        push(0, 1'b0, 32'h200, 32'h0, 32'hA000_0002, 2, 3'b000);
        push(1, 1'b0, 32'h300, 32'h0, 32'hB000_0002, 0, 3'b011);
        repeat (4) serve();

        // Single read on ch0, answered two cycles after mem_read.
        set_req(0, 1'b1, 1'b0, 32'h0000_0100, 32'h0);
        push(0, 1'b0, 32'h100, 32'h0, 32'hCAFE_BABE, 2, 3'b001);
        serve();

        // Read and write both high on ch1: write wins, read slot untouched.
        set_req(1, 1'b1, 1'b1, 32'h0000_0400, 32'h1234_5678);
        push(1, 1'b1, 32'h400, 32'h1234_5678, 32'hDEAD_BEEF, 1, 3'b010);
        serve();

        // Stray mem_response while idle must be ignored.
        bus.mem_response = 1'b1; bus.mem_read_data = 32'h5555_AAAA;
        @(negedge clk);
        bus.mem_response = 1'b0; bus.mem_read_data = '0;
        chk("stray_resp", 64'(bus.ch_response), 64'd0);
        chk("stray_busy", 64'(busy), 64'd0);
        chk("stray_slot0", 64'(rd_slot(0)), 64'(exp_rd[0]));
        @(negedge clk);

        // Last grant is 1, all three request: expect 2, 0, 1.
        set_req(0, 1'b1, 1'b0, 32'h0000_0500, 32'h0);
        set_req(1, 1'b1, 1'b0, 32'h0000_0600, 32'h0);
        set_req(2, 1'b1, 1'b0, 32'h0000_0700, 32'h0);
        push(2, 1'b0, 32'h700, 32'h0, 32'hC000_0002, 0, 3'b100);
        push(0, 1'b0, 32'h500, 32'h0, 32'hC000_0000, 1, 3'b001);
        push(1, 1'b0, 32'h600, 32'h0, 32'hC000_0001, 0, 3'b010);
        repeat (3) serve();

        // Two timeouts: first records channel 2, second leaves it.
        set_req(2, 1'b1, 1'b0, 32'h0000_0800, 32'h0);
        push(2, 1'b0, 32'h800, 32'h0, 32'h0, -1, 3'b100);
        serve();
        set_req(0, 1'b1, 1'b0, 32'h0000_0900, 32'h0);
        push(0, 1'b0, 32'h900, 32'h0, 32'h0, -1, 3'b001);
        serve();

        // Reset while BUSY drops everything immediately.
        set_req(1, 1'b1, 1'b0, 32'h0000_0A00, 32'h0);
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            seen = bus.mem_read;
        end
        chk("midrst_busy_reached", 64'(seen), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_mem_req", 64'({bus.mem_read, bus.mem_write}), 64'd0);
        chk("midrst_grant", 64'(grant), 64'd0);
        chk("midrst_resp", 64'(bus.ch_response), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_terr", 64'(terr), 64'd0);
        chk("midrst_slot2", 64'(rd_slot(2)), 64'd0);
        bus.ch_read = '0;
        bus.ch_write = '0;
        for (int i = 0; i < NP; i++) exp_rd[i] = '0;
        exp_terr = 1'b0; exp_echan = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("postrst_resp", 64'(bus.ch_response), 64'd0);
        set_req(0, 1'b1, 1'b0, 32'h0000_0B00, 32'h0);
        push(0, 1'b0, 32'hB00, 32'h0, 32'h0000_A5A5, 0, 3'b001);
        serve();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/core_bus_arbiter.md
Name: core_bus_arbiter

Overview:
- Shares the controller's single core memory port among NUM_PORTS independent core-side memory buses, e.g. split instruction/data ports or multi-core setups.
- Each channel uses the controller's native protocol: read or write level, address, write_data, read_data, one-cycle response.
- Adds round-robin arbitration, per-channel read-data holding and a watchdog timeout with sticky error reporting.

Parameters:
NUM_PORTS, 2, number of core-side channels (2..8)
BUS_WIDTH, 32, address and data width per channel
TIMEOUT_CYCLES, 1024, BUSY cycles without mem_response before abort; 0 disables the watchdog

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
ch_read  input  NUM_PORTS  read request per channel, held until ch_response
ch_write  input  NUM_PORTS  write request per channel, held until ch_response
ch_address  input  NUM_PORTS*BUS_WIDTH  channel i at [i*BUS_WIDTH +: BUS_WIDTH]
ch_write_data  input  NUM_PORTS*BUS_WIDTH  same packing
ch_read_data  output  NUM_PORTS*BUS_WIDTH  per-channel registered read data
ch_response  output  NUM_PORTS  one-cycle completion pulse per channel
mem_read  output  1  read request to controller
mem_write  output  1  write request to controller
mem_address  output  BUS_WIDTH  registered address
mem_write_data  output  BUS_WIDTH  registered write data
mem_read_data  input  BUS_WIDTH  controller read data, valid with mem_response
mem_response  input  1  controller completion pulse
grant  output  NUM_PORTS  one-hot owner of the current transaction; 0 when idle
busy  output  1  high in BUSY and DONE
timeout_error  output  1  sticky watchdog flag
error_channel  output  $clog2(NUM_PORTS)  channel of the first timeout

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs are 0.
  - State goes to IDLE, last_grant=NUM_PORTS-1, watchdog counter 0.
  - Any in-flight transaction is dropped; no response is generated for it.
- Request definition: req[i] = ch_read[i] | ch_write[i]. If both are high, the operation is a write.
- IDLE:
  - If any req is high, select the first requesting channel scanning from (last_grant+1) mod NUM_PORTS upward, with wrap-around.
  - Latch that channel's address, write_data and op into the mem_* registers.
  - Set grant one-hot and go to BUSY.
  - mem_read/mem_write are asserted in the cycle after the request is sampled (1-cycle latency).
- BUSY:
  - Hold mem_* and grant stable. The watchdog increments every cycle.
  - On mem_response=1:
    - Deassert mem_read/mem_write.
    - For a read, write mem_read_data into the granted channel's ch_read_data slot; writes leave the slot unchanged.
    - Pulse ch_response[g] in the next cycle.
    - Set last_grant=g, clear the watchdog, go to DONE.
  - If TIMEOUT_CYCLES>0 and the watchdog reaches TIMEOUT_CYCLES before mem_response:
    - Abort: deassert mem_*.
    - For a read, load all-ones into the channel's read_data.
    - Pulse ch_response[g]. Set timeout_error=1 and error_channel=g only if timeout_error was 0.
    - Set last_grant=g and go to DONE.
  - mem_response seen outside BUSY is ignored.
- DONE:
  - Exactly one cycle. ch_response[g]=1, busy=1, grant still g.
  - No new grant is issued, so the requester can drop its request.
  - Then go to IDLE; grant goes to 0.
- ch_read_data[i] holds its value until the next read completion on channel i.
- Request changes on non-granted channels never disturb the latched mem_* values.
- Minimum transaction time: 3 cycles (IDLE sample, BUSY with immediate response, DONE).
- timeout_error is cleared only by reset.
- NUM_PORTS=1 degenerates to a registered pass-through with the same latency.

Test Plan:
- Single read: ch_read[0]=1, addr 0x100; controller answers mem_response with 0xCAFEBABE two cycles after mem_read → mem_address=0x100, ch_read_data[0]=0xCAFEBABE, ch_response[0] pulses once; grant returns to 0.
- Simultaneous requests: ch0 and ch1 both read from reset → ch0 served first, then ch1; holding both continuously gives alternating 0,1,0,1 grants.
- Write precedence: ch_read[1]=ch_write[1]=1, data 0x12345678 → mem_write=1, mem_read=0, ch_read_data[1] unchanged.
- Timeout: TIMEOUT_CYCLES=8, no mem_response → abort after 8 BUSY cycles; ch_read_data=0xFFFFFFFF, timeout_error=1, error_channel=granted index. A second timeout leaves error_channel unchanged.
- Reset mid-transaction: reset low during BUSY → mem_read/mem_write/grant/ch_response go to 0 immediately; after release, a fresh request completes normally.
- Three-port rotation: NUM_PORTS=3, all channels requesting after last grant 1 → order 2,0,1; a DONE cycle separates consecutive transactions.
